// File: rtl/mux_arb_reg_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_arb_reg_if : producer/consumer handshake bundle for mux_arb_reg.  Rev 1.0
// ---------------------------------------------------------------------------
interface mux_arb_reg_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_arb_reg : N:1 registered mux, direct-select or round-robin.  Rev 1.0
// ---------------------------------------------------------------------------
module mux_arb_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mux_arb_reg_if.slave bus
);

  logic                out_valid_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_sel_r;
  logic [SEL_W-1:0]    last_r;

  logic                can_load_w;
  logic                grant_valid_w;
  logic [SEL_W-1:0]    grant_idx_w;
  logic [WIDTH-1:0]    grant_data_w;
  logic [CHANNELS-1:0] in_ready_w;
  logic                xfer_in_w;

  assign can_load_w = !out_valid_r || bus.out_ready;

  always_comb begin
    int rr_pos;
    grant_valid_w = 1'b0;
    grant_idx_w   = '0;
    rr_pos        = 0;
    if (!bus.mode) begin
      // An out-of-range SEL never matches any channel, so it yields no grant.
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.sel == SEL_W'(k) && bus.in_valid[SEL_W'(k)]) begin
          grant_valid_w = 1'b1;
          grant_idx_w   = SEL_W'(k);
        end
      end
    end else begin
      // Scan from farthest to nearest so the channel right after LAST wins.
      for (int i = CHANNELS; i >= 1; i--) begin
        rr_pos = int'(last_r) + i;
        if (rr_pos >= CHANNELS) rr_pos = rr_pos - CHANNELS;
        if (bus.in_valid[SEL_W'(rr_pos)]) begin
          grant_valid_w = 1'b1;
          grant_idx_w   = SEL_W'(rr_pos);
        end
      end
    end
  end

  always_comb begin
    grant_data_w = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx_w == SEL_W'(k)) grant_data_w = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready_w = '0;
    if (!rst && can_load_w && grant_valid_w) in_ready_w[grant_idx_w] = 1'b1;
  end

  assign xfer_in_w = can_load_w && grant_valid_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      last_r      <= SEL_W'(CHANNELS - 1);
    end else if (xfer_in_w) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_w;
      out_sel_r   <= grant_idx_w;
      last_r      <= grant_idx_w;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_arb_reg : directed stimulus with queue scoreboard for mux_arb_reg.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_mux_arb_reg;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  mux_arb_reg_if #(.WIDTH(32), .CHANNELS(4)) bus ();

  mux_arb_reg #(.WIDTH(32), .CHANNELS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] pack(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // One cycle of stimulus: drive after the edge, check IN_READY mid-cycle, record
  // the word that will transfer on the coming edge.
  task automatic step(input string name, input logic m, input logic [1:0] s,
                      input logic [3:0] v, input logic [127:0] d, input logic ordy,
                      input logic [3:0] exp_ready);
    exp_t e;
    @(posedge clk);
    #1;
    bus.mode = m; bus.sel = s; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
    #3;
    chk(name, {60'd0, bus.in_ready}, {60'd0, exp_ready});
    for (int k = 0; k < 4; k++) begin
      if (exp_ready == (4'b0001 << k)) begin
        e.data = d[k*32 +: 32];
        e.sel  = 2'(k);
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: each accepted output word must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", {32'd0, bus.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
        chk("out_sel", {62'd0, bus.out_sel}, {62'd0, e.sel});
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0; bus.sel = 2'd0; bus.in_valid = 4'hF;
    bus.in_data = pack(32'hAAAA_0000); bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_in_ready", {60'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    chk("rst_out_sel", {62'd0, bus.out_sel}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; bus.in_valid = 4'h0;

    // Round-robin from LAST=3 with every channel requesting.
    for (int i = 0; i < 5; i++) begin
      step("rr_all", 1'b1, 2'd0, 4'hF, pack(32'h1000 + 32'(i) * 32'h10), 1'b1, 4'b0001 << (i % 4));
      if (i > 0) chk("rr_out_valid", {63'd0, bus.out_valid}, 64'd1);
    end

    // Mid-stream reset once channel 2 sits in the output register.
    step("rr_mid1", 1'b1, 2'd0, 4'hF, pack(32'h1100), 1'b1, 4'b0010);
    step("rr_mid2", 1'b1, 2'd0, 4'hF, pack(32'h1200), 1'b1, 4'b0100);
    @(posedge clk);
    #1;
    chk("pre_rst_sel", {62'd0, bus.out_sel}, 64'd2);
    rst = 1'b1;
    sb.delete();
    #3;
    chk("mid_rst_in_ready", {60'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; bus.in_valid = 4'h0;
    chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    step("rr_after_rst", 1'b1, 2'd0, 4'hF, pack(32'h1300), 1'b1, 4'b0001);

    // Park LAST at 3, then round-robin over the sparse request set.
    step("dir_sel3", 1'b0, 2'd3, 4'hF, pack(32'h2000), 1'b1, 4'b1000);
    step("rr_skip_a", 1'b1, 2'd0, 4'b1010, pack(32'h2100), 1'b1, 4'b0010);
    step("rr_skip_b", 1'b1, 2'd0, 4'b1010, pack(32'h2200), 1'b1, 4'b1000);
    step("rr_skip_c", 1'b1, 2'd0, 4'b1010, pack(32'h2300), 1'b1, 4'b0010);
    step("rr_skip_d", 1'b1, 2'd0, 4'b1010, pack(32'h2400), 1'b1, 4'b1000);

    // Direct select, then a selected channel that is not requesting.
    step("dir_sel2", 1'b0, 2'd2, 4'hF, {32'h3, 32'hDEAD_BEEF, 32'h1, 32'h0}, 1'b1, 4'b0100);
    step("dir_novalid", 1'b0, 2'd1, 4'b1101, pack(32'h3000), 1'b1, 4'b0000);

    // Backpressure: hold 0x1234 for five cycles, then release with a same-edge reload.
    step("bp_load", 1'b0, 2'd1, 4'hF, pack(32'h1233), 1'b1, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", 1'b0, 2'd1, 4'hF, pack(32'h4000 + 32'(i)), 1'b0, 4'b0000);
      chk("bp_out_data", {32'd0, bus.out_data}, 64'h1234);
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    step("bp_release", 1'b1, 2'd0, 4'hF, pack(32'h5000), 1'b1, 4'b0100);
    step("bp_reload_valid", 1'b1, 2'd0, 4'h0, pack(32'h0), 1'b1, 4'b0000);
    chk("bp_reload_out_data", {32'd0, bus.out_data}, 64'h5002);

    // Drained: valid drops, data and index hold.
    step("idle", 1'b1, 2'd0, 4'h0, pack(32'h0), 1'b1, 4'b0000);
    chk("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("idle_out_data", {32'd0, bus.out_data}, 64'h5002);
    chk("idle_out_sel", {62'd0, bus.out_sel}, 64'd2);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
